// File: rtl/flash_pkg.sv
// Shared types and helpers for the Wishbone NOR-flash reader with one-word prefetch.
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    ACK,
    HIT,
    PF,
    ERR
  } state_t;

  localparam int DEFAULT_WAIT_CYCLES = 5;

  function automatic int beats(input int dw);
    return 32 / dw;
  endfunction

  // Byte offset of beat k within a 32-bit word for a dw-bit wide flash.
  function automatic logic [1:0] beat_lsb(input int k, input int dw);
    return 2'(k * (dw / 8));
  endfunction

endpackage

// File: rtl/flash_beat_seq.sv
// Wait-state / beat counter: holds each flash address WAIT_CYCLES cycles and
// strobes the sample on the last cycle of every beat.
module flash_beat_seq #(
  parameter int N_BEATS     = 4,
  parameter int WAIT_CYCLES = 5,
  parameter int BEAT_W      = 2
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              abort,
  output logic [BEAT_W-1:0] beat,
  output logic              sample,
  output logic              done
);

  localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);

  logic              active_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic [BEAT_W-1:0] beat_reg;

  assign sample = active_reg && (wait_reg == WAIT_W'(WAIT_CYCLES - 1));
  assign done   = sample && (beat_reg == BEAT_W'(N_BEATS - 1));
  assign beat   = beat_reg;

  // start wins over abort so a cancelled read can restart in the same cycle
  always_ff @(posedge clk) begin
    if (srst) begin
      active_reg <= 1'b0;
      wait_reg   <= '0;
      beat_reg   <= '0;
    end else if (start) begin
      active_reg <= 1'b1;
      wait_reg   <= '0;
      beat_reg   <= '0;
    end else if (abort) begin
      active_reg <= 1'b0;
    end else if (active_reg) begin
      if (sample) begin
        wait_reg <= '0;
        if (done) active_reg <= 1'b0;
        else      beat_reg   <= beat_reg + 1'b1;
      end else begin
        wait_reg <= wait_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_flash_prefetch.sv
// Wishbone read-only slave for 8/16-bit parallel NOR flash, big-endian beat
// assembly, with a one-word sequential read-ahead buffer.
module wb_flash_prefetch
  import flash_pkg::*;
#(
  parameter int FLASH_DW    = 8,
  parameter int ADDR_W      = 22,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int PREFETCH    = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [ADDR_W-1:0]   flash_adr_o,
  input  logic [FLASH_DW-1:0] flash_dat_i,
  output logic                flash_rst,
  output logic                flash_oe,
  output logic                flash_ce,
  output logic                flash_we,
  output logic                flash_byte_cfg
);

  localparam int N      = beats(FLASH_DW);
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam int WORD_W = ADDR_W - 2;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   word_reg, tag_reg;
  logic [31:0]         buf_reg, dat_reg, buf_merged;
  logic                buf_valid_reg;
  logic [ADDR_W-1:0]   adr_reg;

  logic                acc, start_read, start_pf, seq_abort;
  logic                load_hit, pf_forward, pf_store, buf_clear;
  logic [WORD_W-1:0]   req_word, next_word;
  logic [BEAT_W-1:0]   seq_beat;
  logic                seq_sample, seq_done;
  logic [N-1:0]        beat_hit;
  logic                unused_inputs;

  assign unused_inputs = &{1'b0, wb_dat_i, wb_sel_i, wb_adr_i[1:0], wb_adr_i[31:ADDR_W]};

  assign acc       = wb_cyc_i & wb_stb_i;
  assign req_word  = wb_adr_i[ADDR_W-1:2];
  assign next_word = word_reg + WORD_W'(1);

  assign wb_dat_o       = dat_reg;
  assign wb_ack_o       = (state_reg == ACK) || (state_reg == HIT);
  assign wb_err_o       = (state_reg == ERR);
  assign flash_adr_o    = adr_reg;
  assign flash_rst      = !wb_rst_i;
  assign flash_ce       = !((state_reg == READ) || (state_reg == PF));
  assign flash_oe       = flash_ce;
  assign flash_we       = 1'b1;
  assign flash_byte_cfg = (FLASH_DW == 16);

  flash_beat_seq #(
    .N_BEATS    (N),
    .WAIT_CYCLES(WAIT_CYCLES),
    .BEAT_W     (BEAT_W)
  ) u_seq (
    .clk   (wb_clk_i),
    .srst  (wb_rst_i),
    .start (start_read | start_pf),
    .abort (seq_abort),
    .beat  (seq_beat),
    .sample(seq_sample),
    .done  (seq_done)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_beat
      assign beat_hit[gi] = seq_sample && (seq_beat == BEAT_W'(gi));
    end
  endgenerate

  // The last beat always fills the lowest lane, so a finishing prefetch can
  // be forwarded straight to the bus in its completion cycle.
  always_comb begin
    buf_merged = {buf_reg[31:FLASH_DW], flash_dat_i};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start_read = 1'b0;
    start_pf   = 1'b0;
    seq_abort  = 1'b0;
    load_hit   = 1'b0;
    pf_forward = 1'b0;
    pf_store   = 1'b0;
    buf_clear  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (acc) begin
          if (wb_we_i) begin
            state_next = ERR;
          end else if (buf_valid_reg && (tag_reg == req_word)) begin
            state_next = HIT;
            load_hit   = 1'b1;
          end else begin
            state_next = READ;
            start_read = 1'b1;
          end
        end
      end
      READ: begin
        if (!acc) begin
          state_next = IDLE;
          seq_abort  = 1'b1;
          buf_clear  = 1'b1;
        end else if (seq_done) begin
          state_next = ACK;
        end
      end
      ACK, HIT: begin
        buf_clear = (state_reg == HIT);
        if (PREFETCH != 0) begin
          state_next = PF;
          start_pf   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      PF: begin
        if (acc && (wb_we_i || (req_word != word_reg))) begin
          seq_abort = 1'b1;
          buf_clear = 1'b1;
          if (wb_we_i) begin
            state_next = ERR;
          end else begin
            state_next = READ;
            start_read = 1'b1;
          end
        end else if (seq_done) begin
          if (acc) begin
            state_next = ACK;
            pf_forward = 1'b1;
          end else begin
            state_next = IDLE;
            pf_store   = 1'b1;
          end
        end
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dat_reg       <= '0;
      buf_reg       <= '0;
      buf_valid_reg <= 1'b0;
      tag_reg       <= '0;
      word_reg      <= '0;
      adr_reg       <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (beat_hit[k] && (state_reg == READ)) dat_reg[31-k*FLASH_DW -: FLASH_DW] <= flash_dat_i;
        if (beat_hit[k] && (state_reg == PF))   buf_reg[31-k*FLASH_DW -: FLASH_DW] <= flash_dat_i;
      end
      if (seq_sample && !seq_done)
        adr_reg <= {word_reg, beat_lsb(int'(seq_beat) + 1, FLASH_DW)};
      if (load_hit)   dat_reg <= buf_reg;
      if (pf_forward) dat_reg <= buf_merged;
      if (pf_store) begin
        buf_valid_reg <= 1'b1;
        tag_reg       <= word_reg;
      end
      if (buf_clear) buf_valid_reg <= 1'b0;
      if (load_hit)  word_reg <= req_word;
      if (start_read) begin
        word_reg <= req_word;
        adr_reg  <= {req_word, 2'b00};
      end
      if (start_pf) begin
        word_reg      <= next_word;
        adr_reg       <= {next_word, 2'b00};
        buf_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wb_flash_prefetch.md
Name: wb_flash_prefetch

Overview:
- Wishbone slave that reads 32-bit words from a parallel NOR flash that is 8 or 16 bits wide.
- Read timing is parametrised by wait state; read beats are big-endian.
- A one-word sequential prefetch buffer returns the next instruction word with single-cycle latency.
- Sits between the CPU instruction/data Wishbone bus and the board flash pins; writes are rejected with an error.

Parameters:
- FLASH_DW, 8, flash data width; legal values 8 or 16.
- ADDR_W, 22, flash byte-address bits driven on flash_adr_o.
- WAIT_CYCLES, 5, cycles each flash address is held before sampling; must be >=1.
- PREFETCH, 1, 1 enables next-word read-ahead; 0 disables the buffer.

Ports:
- wb_clk_i  in  1  clock; all logic on its rising edge.
- wb_rst_i  in  1  reset.
- wb_adr_i  in  32  byte address; bits [ADDR_W-1:2] used.
- wb_dat_i  in  32  ignored.
- wb_sel_i  in  4  ignored; a full word is always returned.
- wb_we_i  in  1  write strobe.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  one-cycle read acknowledge.
- wb_err_o  out  1  one-cycle write error.
- flash_adr_o  out  ADDR_W  flash byte address.
- flash_dat_i  in  FLASH_DW  flash read data.
- flash_rst  out  1  flash reset, active low.
- flash_oe  out  1  output enable, active low.
- flash_ce  out  1  chip enable, active low.
- flash_we  out  1  write enable, active low; tied 1.
- flash_byte_cfg  out  1  1 when FLASH_DW==16, else 0.

Behaviour:
- Clock/reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: wb_dat_o=0, wb_ack_o=0, wb_err_o=0, flash_adr_o=0, flash_ce=1, flash_oe=1, buffer invalid, state IDLE.
- flash_rst = !wb_rst_i.
- Reset mid-operation: abort immediately, no ack.
- Request: acc = wb_cyc_i & wb_stb_i, sampled only in IDLE or PF.
- Beats: N = 32/FLASH_DW (4 or 2).
  - Beat k address = {wb_adr_i[ADDR_W-1:2], k*(FLASH_DW/8)}, with low bits sized to ADDR_W.
  - Beat 0 lands in wb_dat_o[31:32-FLASH_DW]; later beats fill downward.
- Beat timing: address held WAIT_CYCLES cycles; flash_dat_i sampled on the last one; next beat's address is driven the following cycle.
- flash_ce = flash_oe = 0 exactly while in READ or PF.
- States:
  - IDLE
    - acc & wb_we_i -> ERR.
    - acc & read & buffer hit (valid, tag == wb_adr_i word) -> HIT.
    - acc & read & miss -> READ.
  - READ: runs N beats, then -> ACK.
    - wb_cyc_i or wb_stb_i low mid-read -> IDLE; no ack; buffer invalid.
  - ACK: wb_ack_o=1 for one cycle with wb_dat_o valid.
    - PREFETCH=1 -> PF, target = word+4, wrapping modulo 2^ADDR_W.
    - Otherwise -> IDLE.
  - HIT: wb_dat_o <= buffer, wb_ack_o=1 for one cycle, buffer invalid.
    - PREFETCH=1 -> PF on word+4; otherwise -> IDLE.
  - PF: reads N beats into the buffer (not wb_dat_o), then sets valid and tag -> IDLE.
    - acc read matching the PF target: continue; on PF completion go straight to ACK with the buffer data (buffer consumed, not left valid).
    - acc read not matching, or any write: abort PF, buffer invalid, then handle as from IDLE in the same cycle.
  - ERR: wb_err_o=1 for one cycle -> IDLE. No flash activity; flash_ce stays 1.
- Latency (request first seen in cycle 0):
  - Miss: ack in cycle N*WAIT_CYCLES+1.
  - Hit: ack in cycle 1.
  - Write: err in cycle 1.
- Back-to-back: ack and err are never asserted two consecutive cycles for the same request. The master must drop stb or change the address after the ack.
- ack and err are mutually exclusive.

Decomposition:
- Package flash_pkg: state enum (IDLE, READ, ACK, HIT, PF, ERR), function beats(FLASH_DW), default WAIT_CYCLES constant.
- One sub-module, flash_beat_seq: wait/beat counter. Inputs start and abort; outputs beat index, sample strobe, done. Shared by READ and PF.

Test Plan:
- FLASH_DW=8, WAIT_CYCLES=5; flash model returns the low address byte; read 0x100 -> flash_adr_o 0x100..0x103; ack at cycle 21; wb_dat_o=0x00010203.
- After the first test's prefetch completes, read 0x104 -> ack at cycle 1; wb_dat_o=0x04050607; a new PF starts on 0x108.
- Read 0x200 during PF of 0x104 -> PF aborted; flash_adr_o jumps to 0x200 the next cycle; ack at cycle 21; data 0x00010203 pattern for 0x200.
- Write to 0x100 -> wb_err_o pulse at cycle 1; wb_ack_o stays 0; flash_ce stays 1 throughout.
- FLASH_DW=16, WAIT_CYCLES=3 -> 2 beats at addresses 0x0 and 0x2; ack at cycle 7; flash_byte_cfg=1.
- Read of last word 0x3FFFFC (ADDR_W=22) -> PF targets 0x000000. Reset asserted at cycle 3 of a read -> no ack; outputs at reset values next cycle.
